// File: rtl/hv_adc_avg.sv
// ADC sample averager: synchronizes the analog conversion-done level, accumulates a
// window of 1/2/4/8 samples and emits the truncated mean with a one-cycle strobe.
module hv_adc_avg #(
  parameter int SYNC_STAGES = 2,
  parameter int TMO_CYC     = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_avg_en,
  input  logic [1:0] i_avg_sel,
  input  logic [9:0] i_adc_data,
  input  logic       i_adc_ready,
  input  logic       i_tmo_clr,
  output logic [9:0] o_adc_data,
  output logic       o_adc_ready,
  output logic       o_adc_tmo
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   rdy_prev_p1;
  logic                   smp_evt;

  logic [1:0]       win_sel;
  logic [3:0]       win_n;
  logic [12:0]      acc;
  logic [2:0]       cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic start_win;
  logic acc_add;
  logic last_smp;
  logic tmo_hit;

  // Window mean: divide by the power-of-two window size, dropping the fraction.
  function automatic logic [9:0] avg_trunc(input logic [12:0] sum, input logic [1:0] sh);
    return 10'(sum >> sh);
  endfunction

  // Stage p0: metastability chain; p1: previous synced level for rise detection.
  // Kept running while disabled so a level already high at re-enable is not an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_p0     <= '0;
      rdy_prev_p1 <= 1'b0;
    end else begin
      sync_p0     <= {sync_p0[SYNC_STAGES-2:0], i_adc_ready};
      rdy_prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign smp_evt = sync_p0[SYNC_STAGES-1] & ~rdy_prev_p1;

  assign win_n     = 4'd1 << win_sel;
  assign start_win = i_avg_en && smp_evt && (state == IDLE || state == DONE);
  assign acc_add   = i_avg_en && smp_evt && (state == ACC);
  assign last_smp  = acc_add && (({1'b0, cnt} + 4'd1) == win_n);
  assign tmo_hit   = i_avg_en && (state == ACC) && !smp_evt &&
                     (tmo_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!i_avg_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (smp_evt) state_nx = (i_avg_sel == 2'd0) ? DONE : ACC;
        end
        ACC: begin
          if (last_smp)     state_nx = DONE;
          else if (tmo_hit) state_nx = IDLE;
        end
        DONE: begin
          // A new sample in the output cycle opens the next window immediately.
          if (smp_evt) state_nx = (i_avg_sel == 2'd0) ? DONE : ACC;
          else         state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage p2: accumulate samples and timeout tracking.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      win_sel <= 2'd0;
      acc     <= '0;
      cnt     <= '0;
      tmo_cnt <= '0;
    end else if (!i_avg_en) begin
      acc     <= '0;
      cnt     <= '0;
      tmo_cnt <= '0;
    end else if (start_win) begin
      win_sel <= i_avg_sel;
      acc     <= {3'b000, i_adc_data};
      cnt     <= 3'd1;
      tmo_cnt <= '0;
    end else if (acc_add) begin
      acc     <= acc + {3'b000, i_adc_data};
      cnt     <= cnt + 3'd1;
      tmo_cnt <= '0;
    end else if (tmo_hit) begin
      acc     <= '0;
      cnt     <= '0;
      tmo_cnt <= '0;
    end else if (state == ACC) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Output stage: result and strobe registered out of the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_adc_data  <= 10'h000;
      o_adc_ready <= 1'b0;
      o_adc_tmo   <= 1'b0;
    end else begin
      o_adc_ready <= 1'b0;
      if (i_avg_en && state == DONE) begin
        o_adc_data  <= avg_trunc(acc, win_sel);
        o_adc_ready <= ~o_adc_ready;
      end
      if (tmo_hit)        o_adc_tmo <= 1'b1;
      else if (i_tmo_clr) o_adc_tmo <= 1'b0;
    end
  end

endmodule
